// File: rtl/conv_puncturer_serializer.sv
// Punctures 16-bit rate-1/2 codewords to rate 1/2, 2/3 or 3/4 and serializes the kept
// bits one per cycle. The puncture phase runs continuously across words of the same rate.
module conv_puncturer_serializer (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  rate_sel,
    input  logic [15:0] data_in,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        out_bit,
    output logic        out_valid,
    output logic        out_last,
    input  logic        out_ready
);

    // Kept slots of one pair: bit 1 = A, bit 0 = B. Every pattern keeps at least one bit.
    function automatic logic [1:0] keep_mask(input logic [1:0] rate, input logic [1:0] phase);
        logic [1:0] m;
        m = 2'b11;
        case (rate)
            2'd1: m = (phase == 2'd1) ? 2'b10 : 2'b11;
            2'd2: begin
                case (phase)
                    2'd1:    m = 2'b01;
                    2'd2:    m = 2'b10;
                    default: m = 2'b11;
                endcase
            end
            default: m = 2'b11;
        endcase
        return m;
    endfunction

    function automatic logic [1:0] next_phase(input logic [1:0] rate, input logic [1:0] phase);
        logic [1:0] p;
        p = 2'd0;
        case (rate)
            2'd1:    p = (phase == 2'd0) ? 2'd1 : 2'd0;
            2'd2:    p = (phase == 2'd2) ? 2'd0 : phase + 2'd1;
            default: p = 2'd0;
        endcase
        return p;
    endfunction

    // Rate 11 is folded onto 1/2 so the rate-change comparison treats them alike.
    function automatic logic [1:0] norm_rate(input logic [1:0] rate);
        return (rate == 2'd3) ? 2'd0 : rate;
    endfunction

    logic [15:0] word_q, word_d;
    logic [1:0]  rate_q, rate_d;
    logic [2:0]  pair_q, pair_d;
    logic        sub_q, sub_d;
    logic [1:0]  phase_q, phase_d;
    logic        full_q, full_d;

    logic [1:0]  cur_mask_s;
    logic [1:0]  nxt_mask_s;
    logic [1:0]  new_rate_s;
    logic [3:0]  bit_idx_s;
    logic        pair_last_s;
    logic        fire_s;
    logic        accept_s;

    // Output decode from registered state, plus next-state for advance and accept.
    always_comb begin
        word_d     = word_q;
        rate_d     = rate_q;
        pair_d     = pair_q;
        sub_d      = sub_q;
        phase_d    = phase_q;
        full_d     = full_q;
        nxt_mask_s = 2'b11;
        new_rate_s = norm_rate(rate_sel);

        cur_mask_s  = keep_mask(rate_q, phase_q);
        pair_last_s = sub_q | ~cur_mask_s[0];
        bit_idx_s   = 4'd15 - {pair_q, sub_q};
        out_valid   = full_q;
        out_bit     = full_q & word_q[bit_idx_s];
        out_last    = full_q & pair_last_s & (pair_q == 3'd7);
        fire_s      = full_q & out_ready;
        in_ready    = ~full_q | (fire_s & out_last);
        accept_s    = in_valid & in_ready;

        if (fire_s) begin
            if (pair_last_s) begin
                phase_d    = next_phase(rate_q, phase_q);
                pair_d     = pair_q + 3'd1;
                nxt_mask_s = keep_mask(rate_q, phase_d);
                sub_d      = ~nxt_mask_s[1];
                full_d     = (pair_q != 3'd7);
            end else begin
                sub_d = 1'b1;
            end
        end else begin
            sub_d = sub_q;
        end

        // Phase carries over unless the incoming word switches rate.
        if (accept_s) begin
            word_d     = data_in;
            rate_d     = new_rate_s;
            pair_d     = 3'd0;
            full_d     = 1'b1;
            phase_d    = (new_rate_s != rate_q) ? 2'd0 : phase_d;
            nxt_mask_s = keep_mask(new_rate_s, phase_d);
            sub_d      = ~nxt_mask_s[1];
        end else begin
            word_d = word_d;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            word_q  <= 16'd0;
            rate_q  <= 2'd0;
            pair_q  <= 3'd0;
            sub_q   <= 1'b0;
            phase_q <= 2'd0;
            full_q  <= 1'b0;
        end else begin
            word_q  <= word_d;
            rate_q  <= rate_d;
            pair_q  <= pair_d;
            sub_q   <= sub_d;
            phase_q <= phase_d;
            full_q  <= full_d;
        end
    end

endmodule

// File: doc/conv_puncturer_serializer.md
# conv_puncturer_serializer

Downstream stage of `convolutional_encoder`. Accepts 16-bit rate-1/2 codewords (8 symbol pairs A/B) over a valid/ready handshake. Punctures them to rate 1/2, 2/3 or 3/4 with a pattern phase that runs continuously across words. Emits the kept bits one per cycle on a serial valid/ready stream toward the modulator.

## Interface
- No parameters; widths fixed.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high.
- `rate_sel`  in  2  puncturing rate: 00 = 1/2, 01 = 2/3, 10 = 3/4, 11 = treated as 1/2. Sampled only on word acceptance.
- `data_in`  in  16  codeword. Pair i (i = 0..7, sent first to last): A = `data_in[15-2i]`, B = `data_in[14-2i]`.
- `in_valid`  in  1  `data_in` and `rate_sel` are valid.
- `in_ready`  out  1  block can accept a word this cycle.
- `out_bit`  out  1  current serial bit.
- `out_valid`  out  1  `out_bit` is valid.
- `out_last`  out  1  `out_bit` is the last kept bit of its word.
- `out_ready`  in  1  downstream consumes `out_bit` this cycle.

## Operation
- Storage: one word register; latched rate; pair index (0..7); sub-bit select (A/B); pattern phase counter.
- Puncture patterns per pair, by phase (A emitted before B within a pair):
  - Rate 1/2: every pair emits A, B (16 bits per word).
  - Rate 2/3: phase period 2. Phase 0 emits A, B; phase 1 emits A only (12 bits per word).
  - Rate 3/4: phase period 3. Phase 0 emits A, B; phase 1 emits B only; phase 2 emits A only.
- Every pair emits at least one bit, so the serializer never stalls on a fully punctured pair.
- Phase advances by one per pair (mod period) and carries across word boundaries. Under 3/4, word n starts at phase (8n mod 3).
- Phase resets to 0:
  - on `reset`;
  - when an accepted word's `rate_sel` differs from the latched rate (the new rate is latched at the same time).
- Accept: when `in_valid && in_ready`, load the word, latch the rate, set pair index 0, and select the first kept bit of pair 0.
- Advance: when `out_valid && out_ready`, move to the next kept bit. Skipped punctured slots cost no cycles. After the last kept bit of pair 7, the word register empties.
- `in_ready` = register empty, or (`out_valid && out_ready && out_last`). This gives back-to-back words with no bubble.
- `out_bit`, `out_valid` and `out_last` derive only from registered state. There is no combinational path from `data_in`, `in_valid` or `rate_sel` to the outputs. `in_ready` may depend combinationally on `out_ready`.

## Timing
- Reset values: `out_valid` = 0, `out_bit` = 0, `out_last` = 0, `in_ready` = 1; phase = 0; latched rate = 1/2; register empty.
- Latency: word accepted at edge t gives its first bit with `out_valid` = 1 in the cycle after t.
- Throughput: one bit per cycle while `out_ready` = 1, including across word boundaries.
- Backpressure: while `out_valid && !out_ready`, `out_bit`/`out_last` stay stable and `in_ready` = 0.
- Reset mid-word: the remaining bits are discarded. Next cycle: `out_valid` = 0 and phase = 0.
- `in_valid` while `in_ready` = 0: the word is not taken; upstream must hold it.
- Rate 11: behaves exactly as 1/2, including the rate-change phase-reset comparison.

## Test plan
- Rate 1/2, `data_in` = 16'hA5C3, `out_ready` = 1:
  - bits 1010010111000011 on 16 consecutive cycles;
  - `out_last` on the 16th bit, with `in_ready` = 1 that cycle.
- Rate 2/3, 16'hAAAA:
  - 12 bits 101101101101;
  - `out_last` on the 12th bit;
  - next word starts at phase 0.
- Rate 3/4, two back-to-back 16'hAAAA words:
  - word 1 = 10011001100 (11 bits, ends at phase 2);
  - word 2 = 11001100110 (11 bits, starts at phase 2);
  - no idle cycle between the words.
- Backpressure at rate 1/2, 16'hFFFF, `out_ready` toggling 1,0,0,1,…:
  - `out_bit` held during stalls;
  - exactly 16 handshakes;
  - `in_ready` = 0 until the last handshake.
- Reset mid-word:
  - `reset` pulsed after 5 bits of a 3/4 word: `out_valid` = 0 the next cycle.
  - A following 3/4 word 16'hAAAA then produces 10011001100 (phase restarted at 0).
- Rate change:
  - 3/4 word 16'hAAAA, then 2/3 word 16'hAAAA;
  - second word emits 101101101101 (phase reset on the rate change).
